// File: rtl/i2c_sensor_pkg.sv
// Shared constants and enums for the I2C sensor raw-code to engineering-unit converter.
package i2c_sensor_pkg;

  localparam logic [15:0] K_TEMP   = 16'd17572;
  localparam logic [15:0] K_HUMI   = 16'd12500;
  localparam logic [15:0] OFF_TEMP = 16'd4685;
  localparam logic [16:0] OFF_HUMI = 17'd600;
  localparam logic [16:0] RH_MAX   = 17'd10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADJ  = 2'd2
  } conv_state_e;

  typedef enum logic {
    CH_TEMP = 1'b0,
    CH_HUMI = 1'b1
  } chan_e;

endpackage

// File: rtl/i2c_sensor_convert_seq_mul16x16.sv
// 16-cycle shift-add unsigned multiplier, multiplier bits consumed LSB first.
// done is high during the final accumulate cycle; product is complete after that edge.
module seq_mul16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic        done,
  output logic [31:0] product
);

  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  bit_idx;
  logic        running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      bit_idx <= '0;
      running <= 1'b0;
      product <= '0;
    end else if (start) begin
      mcand   <= multiplicand;
      mplier  <= multiplier;
      bit_idx <= '0;
      running <= 1'b1;
      product <= '0;
    end else if (running) begin
      if (mplier[bit_idx])
        product <= product + (32'(mcand) << bit_idx);
      bit_idx <= bit_idx + 4'd1;
      if (bit_idx == 4'd15)
        running <= 1'b0;
    end
  end

  assign done = running && (bit_idx == 4'd15);

endmodule

// File: rtl/i2c_sensor_convert.sv
// Converts raw I2C sensor words into centi-degC temperature and centi-percent RH.
// state | meaning
// IDLE  | waiting for measure_done; accepts a word and starts the multiplier
// MUL   | 16 shift-add steps of code * K
// ADJ   | offset/clamp the product high half and update the channel output
module i2c_sensor_convert
  import i2c_sensor_pkg::*;
#(
  parameter bit FIRST_IS_HUMI = 1'b1,
  parameter bit CLAMP_RH      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        measure_done,
  input  logic [15:0] i2c_data,
  output logic [15:0] temp_cdeg,
  output logic [13:0] rh_cpct,
  output logic        temp_valid,
  output logic        rh_valid,
  output logic        busy,
  output logic        overrun
);

  conv_state_e state, state_next;
  chan_e       chan_reg, chan;
  logic        mul_start, mul_done;
  logic [31:0] product;
  logic [15:0] q;
  logic [16:0] rh_diff;
  logic [13:0] rh_next;

  assign mul_start = (state == IDLE) && measure_done;

  seq_mul16x16 u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand ((chan_reg == CH_HUMI) ? K_HUMI : K_TEMP),
    .multiplier   ({i2c_data[15:2], 2'b00}),
    .done         (mul_done),
    .product      (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (measure_done) state_next = MUL;
      MUL:     if (mul_done)     state_next = ADJ;
      ADJ:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign q       = 16'(product >> 16);
  assign rh_diff = {1'b0, q} - OFF_HUMI;

  // bit 16 of rh_diff is the sign: q < OFF_HUMI wraps negative
  always_comb begin
    rh_next = rh_diff[13:0];
    if (CLAMP_RH) begin
      if (rh_diff[16])
        rh_next = '0;
      else if (rh_diff > RH_MAX)
        rh_next = RH_MAX[13:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_reg   <= FIRST_IS_HUMI ? CH_HUMI : CH_TEMP;
      chan       <= CH_TEMP;
      temp_cdeg  <= '0;
      rh_cpct    <= '0;
      temp_valid <= 1'b0;
      rh_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      rh_valid   <= 1'b0;
      // dropped words still toggle the channel to stay in step with the master
      if (measure_done) begin
        chan_reg <= (chan_reg == CH_HUMI) ? CH_TEMP : CH_HUMI;
        if (state == IDLE) chan    <= chan_reg;
        else               overrun <= 1'b1;
      end
      if (state == ADJ) begin
        if (chan == CH_TEMP) begin
          temp_cdeg  <= q - OFF_TEMP;
          temp_valid <= 1'b1;
        end else begin
          rh_cpct  <= rh_next;
          rh_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/i2c_sensor_convert.md
Name: i2c_sensor_convert

Overview:
- Sits directly downstream of the I2C sensor master.
- Captures each 16-bit raw measurement word on the master's one-cycle `measure_done` strobe.
- Converts it with a sequential shift-add multiplier to fixed-point engineering units: temperature in signed centi-degrees C, relative humidity in unsigned centi-percent.
- Presents the latest value of each channel with a one-cycle valid strobe for display/UART stages.

Parameters:
- `FIRST_IS_HUMI`, 1, channel of the first measurement after reset (1 = humidity, 0 = temperature). Channels then strictly alternate, matching the master's sequence.
- `CLAMP_RH`, 1, when 1 the RH result is saturated to 0..10000.

Ports:
- `clk`  in  1  system clock, shared with the I2C master.
- `rst`  in  1  reset, asynchronous, active-high.
- `measure_done`  in  1  one-cycle strobe from the master; `i2c_data` is stable when it is high.
- `i2c_data`  in  16  raw sensor code, MSB first; bits [1:0] are status bits.
- `temp_cdeg`  out  16  signed temperature ×100 (°C).
- `rh_cpct`  out  14  unsigned RH ×100 (%).
- `temp_valid`  out  1  one-cycle pulse when `temp_cdeg` updates.
- `rh_valid`  out  1  one-cycle pulse when `rh_cpct` updates.
- `busy`  out  1  high while a conversion is in progress.
- `overrun`  out  1  sticky flag: a strobe arrived while busy. Cleared only by `rst`.

Behaviour:
- Reset is asynchronous and active-high, using the codebase's single clock `clk` and reset `rst`.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - channel register = `FIRST_IS_HUMI`.
- States: IDLE, MUL, ADJ.
- IDLE, on `measure_done`=1 at edge T:
  - latch `code = {i2c_data[15:2], 2'b00}`;
  - latch `chan` = channel register, then toggle the channel register;
  - select coefficient K: 17572 for temperature, 12500 for humidity;
  - clear the 32-bit accumulator, set bit counter to 0;
  - go to MUL; `busy`=1 from T.
- MUL, edges T+1..T+16:
  - process code bits LSB first: if `code[i]`, `acc += K << i`;
  - after bit 15 (edge T+16), go to ADJ.
- ADJ, edge T+17:
  - compute `q = acc[31:16]` (truncation, no rounding).
  - Temperature: `temp_cdeg <= q - 4685` in 16-bit two's complement. Range is −4685..12885, so it never overflows. Assert `temp_valid`.
  - Humidity: `r = q - 600`, signed 17-bit.
    - With `CLAMP_RH`=1: `r < 0` gives 0; `r > 10000` gives 10000.
    - With `CLAMP_RH`=0: take the low 14 bits of `r` (wraps).
    - `rh_cpct <= r`. Assert `rh_valid`.
  - Go to IDLE; `busy`=0 after edge T+17.
- Latency: the valid pulse is high for exactly the one cycle following edge T+17, i.e. 18 clocks after the strobe is sampled. Throughput is one conversion per 18 clocks.
- Outputs hold their last values until the next update of the same channel. The other channel's output is never disturbed.
- `measure_done` while busy (MUL/ADJ):
  - the word is dropped and `overrun` is set;
  - the channel register still toggles, so alternation stays aligned with the master;
  - the in-flight conversion completes normally.
- `measure_done` at edge T+17 (the ADJ edge) counts as busy. The next strobe is accepted from edge T+18.
- `rst` mid-conversion: abort immediately to reset values. No valid pulse is produced.
- `measure_done` high for multiple cycles is illegal. Each high cycle is treated as a separate strobe (the later ones overrun).

Decomposition:
- Package `i2c_sensor_pkg` holds:
  - `K_TEMP`=17572, `K_HUMI`=12500;
  - `OFF_TEMP`=4685, `OFF_HUMI`=600, `RH_MAX`=10000;
  - `conv_state_e` {IDLE, MUL, ADJ};
  - channel enum {CH_TEMP, CH_HUMI}.
- One sub-module: `seq_mul16x16`, a start/done 16-cycle shift-add unsigned multiplier with 32-bit product. The FSM, offset and clamp stay in the top level.

Test Plan:
- Reset, then strobe with 0x7C80 (humidity first) → after 18 clocks `rh_valid` pulses once and `rh_cpct`=5479; `temp_cdeg` stays 0.
- Next strobe 0x6640 (temperature) → `temp_cdeg`=2333 (0x091D) and `temp_valid` pulses. Repeat with 0x6643 → same 2333, confirming status-bit masking.
- Boundaries:
  - humidity 0xFFFF → `rh_cpct`=10000 (clamped); humidity 0x0000 → 0 (clamped);
  - temperature 0x0000 → `temp_cdeg`=−4685 (0xEDB3); temperature 0xFFFF → 12885.
- Second strobe 5 clocks after the first → `overrun`=1; the first result is still correct; the next accepted strobe is decoded as the channel after the dropped one.
- Assert `rst` during MUL (clock 8 of a conversion) → all outputs 0 immediately, no valid pulse. After release, the first strobe is decoded per `FIRST_IS_HUMI`.
- Back-to-back strobes exactly 18 clocks apart for 10 conversions → every word is converted, no overrun, and channels alternate H,T,H,T...
